disp_src_sched: RTL and testbench
=================================

# disp_src_sched

Round-robin scheduler that shares the single 4-digit DISPLAY datapath among up to four 16-bit requesters, such as counter chains and switch readbacks. It dwells on each requesting source for a programmable number of 1 ms ticks, or advances on a button press in manual mode. It drives DISPLAY's `dat` and `PTR` inputs, and exports the current grant so the top level can light an indicator LED. It sits between the counter chain and DISPLAY, clocked from the BUFG'd 50 MHz clock, and uses the 1 ms clock-enable from Gen_Nms_1s.

## Interface
- `DWELL_MS`, default 1000: number of `ce1ms` ticks each source is shown in auto mode; legal range 1..65535.
- `clk` in 1: system clock (BUFG 50 MHz).
- `clr_n` in 1: asynchronous, active-low reset.
- `ce1ms` in 1: 1 ms clock-enable pulse, one `clk` wide.
- `src_dat` in 64: source data; source i occupies `[16*i+15:16*i]`.
- `src_req` in 4: level request, one bit per source; bit high means the source wants display time.
- `mode` in 1: 0 selects auto round-robin; 1 selects manual.
- `btn_next` in 1: manual advance; level input, already debounced. The block edge-detects it internally.
- `dat` out 16: data to DISPLAY.
- `PTR` out 4: one-hot decimal point marking the granted source index; 0 when idle.
- `grant` out 4: one-hot grant; 0 when idle.
- `sel` out 2: index of the granted source.
- `CEO` out 1: one-`clk` pulse on every grant change.

## Operation
- **States**
  - IDLE: `src_req`==0. Outputs `grant`=0, `PTR`=0, `dat`=0, `sel` holds its last value.
  - SHOW: exactly one source is granted.
- **Pick function**
  - Takes the first requesting index, searching cyclically from `sel`+1 (mod 4).
  - If no other source requests and `src_req[sel]` is still set, the pick is `sel` itself.
- **IDLE -> SHOW**
  - Triggered when any `src_req` bit is high.
  - Grant goes to the pick, `CEO` pulses, and the dwell counter clears.
- **SHOW -> SHOW (switch)** on any of these:
  - Auto mode and the `ce1ms` pulse that brings the dwell count to `DWELL_MS`.
  - Manual mode and a rising edge of `btn_next`.
  - The granted source drops its `src_req` while another source is requesting. The switch is immediate, and both modes do this.
- **Switch rules**
  - `CEO` pulses only if the picked index differs from the old one.
  - If the pick equals the current source, the grant stays and the dwell counter restarts with no `CEO`.
- **SHOW -> IDLE**
  - Triggered when `src_req` becomes 0. `CEO` pulses.
- **Dwell counter**
  - 16 bits wide.
  - Increments on `ce1ms` only in SHOW with `mode`=0.
  - Frozen in manual mode.
  - Clears on every grant event.
- **Mode change**
  - Changing `mode` mid-dwell keeps the current grant.
  - The counter resumes from its frozen value.
- **Data path**
  - `dat` is registered from `src_dat` of the next-cycle grant.
  - `dat` follows a granted source's data changes with 1 cycle of latency.
- **Reset** (`clr_n` low, asynchronous)
  - All of the following clear immediately: state=IDLE, `sel`=0, `grant`=0, `PTR`=0, `dat`=0, `CEO`=0, dwell counter=0, button edge register=0.
  - A reset mid-dwell discards the dwell count.
  - After reset release the first pick starts from index 1, because `sel`=0.

## Timing
- Every output is registered; there is no combinational path from inputs to outputs.
- `grant`, `sel`, `PTR`, `dat` and `CEO` all update on the same rising edge as the triggering condition is sampled.
- **Auto dwell**
  - The grant changes on the edge that samples the `DWELL_MS`-th `ce1ms` after grant.
  - One-cycle `ce1ms` pulses must be counted exactly once.
- **`btn_next`**
  - Edge detect uses a single register, so the switch occurs on the edge after the input rises.
  - Holding the button high gives exactly one switch.
- **Simultaneous events in one cycle**
  - Request drop, dwell expiry and button edge together cause one switch only.
  - Reset overrides everything.

## Configuration
- **`SCHED_PRIO_EN` defined**
  - Source 0 is high priority: a rising edge of `src_req[0]` pre-empts any other grant on the next edge (`CEO` pulses, counter clears), in both modes.
  - While granted, source 0 is never switched away by dwell expiry or the button as long as `src_req[0]` is held.
- **Undefined**
  - Source 0 is treated as a plain round-robin member.

## Test plan
- Reset with `DWELL_MS`=4, `src_req`=4'b1111, `mode`=0 → `grant` cycles 0010, 0100, 1000, 0001, every 4 `ce1ms`. One `CEO` per change. `PTR` equals `grant`. `dat` equals the granted source's data, e.g. 16'h1234 for source 1.
- `src_req`=4'b0100 only → `grant` = 0100 held across 20 ticks, no `CEO` after the first. Then `src_req`=0 → IDLE: `dat`=0, `grant`=0, one `CEO`.
- `mode`=1, `src_req`=4'b1010, `btn_next` held high for 100 cycles → exactly one switch from 0010 to 1000. No switch on any `ce1ms`.
- Source 2 granted with 2 ticks of dwell elapsed, then `src_req[2]` drops while bit 3 is set → `grant`=1000 on the next edge, and the counter restarts from 0.
- Assert `clr_n` low asynchronously mid-dwell → all outputs 0 before the next `clk` edge. After release, the first pick is index 1.
- With `SCHED_PRIO_EN`: source 2 granted, raise `src_req[0]` → `grant`=0001 on the next edge, and it stays through dwell expiry. Without the macro, source 0 waits its round-robin turn.

Source files
------------

// File: rtl/disp_src_sched.sv
// Round-robin scheduler that shares the 4-digit DISPLAY datapath among four 16-bit sources.
// Optional build macro SCHED_PRIO_EN: source 0 pre-empts on a rising request and is never dwelled away.
module disp_src_sched #(
  parameter int unsigned DWELL_MS = 1000
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        ce1ms,
  input  logic [63:0] src_dat,
  input  logic [3:0]  src_req,
  input  logic        mode,
  input  logic        btn_next,
  output logic [15:0] dat,
  output logic [3:0]  PTR,
  output logic [3:0]  grant,
  output logic [1:0]  sel,
  output logic        CEO
);

  localparam int unsigned NSRC = 4;
  localparam int unsigned DW   = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     dwell, dwell_nxt;
  logic [DW-1:0]     dat_nxt;
  logic [NSRC-1:0]   grant_nxt;
  logic [1:0]        pick, sel_nxt;
  logic              btn_q, btn_rise;
  logic              expire, grant_ev, ceo_nxt;
  logic              preempt, hold_prio;

  assign btn_rise = btn_next & ~btn_q;
  assign expire   = ~mode & ce1ms & (dwell == DW'(DWELL_MS - 1));

`ifdef SCHED_PRIO_EN
  logic req0_q;

  // Remembers the previous source-0 request so a rising request can pre-empt.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) req0_q <= 1'b0;
    else        req0_q <= src_req[0];
  end

  assign preempt   = src_req[0] & ~req0_q;
  assign hold_prio = (state == SHOW) && (sel == 2'd0) && src_req[0];
`else
  assign preempt   = 1'b0;
  assign hold_prio = 1'b0;
`endif

  // First requesting index searching cyclically from sel+1; falls back to sel itself.
  always_comb begin
    pick = sel;
    for (int i = NSRC - 1; i >= 1; i--) begin
      if (src_req[sel + 2'(i)]) pick = sel + 2'(i);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state plus the grant decision; a single switch regardless of how many triggers coincide.
  always_comb begin
    state_nxt = state;
    grant_ev  = 1'b0;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (|src_req) begin
          state_nxt = SHOW;
          grant_ev  = 1'b1;
          sel_nxt   = preempt ? 2'd0 : pick;
        end
      end
      SHOW: begin
        if (src_req == '0) begin
          state_nxt = IDLE;
        end else if (preempt && (sel != 2'd0)) begin
          grant_ev = 1'b1;
          sel_nxt  = 2'd0;
        end else if (!src_req[sel] || (!hold_prio && (expire || (mode && btn_rise)))) begin
          grant_ev = 1'b1;
          sel_nxt  = pick;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and the dwell counter.
  always_comb begin
    ceo_nxt   = (state_nxt != state) || (grant_ev && (sel_nxt != sel));
    dwell_nxt = dwell;
    if (grant_ev || (state_nxt == IDLE)) dwell_nxt = '0;
    else if ((state == SHOW) && !mode && ce1ms) dwell_nxt = dwell + DW'(1);
    grant_nxt = '0;
    dat_nxt   = '0;
    if (state_nxt == SHOW) begin
      grant_nxt[sel_nxt] = 1'b1;
      dat_nxt            = src_dat[{sel_nxt, 4'b0000} +: DW];
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sel   <= '0;
      grant <= '0;
      PTR   <= '0;
      dat   <= '0;
      CEO   <= 1'b0;
      dwell <= '0;
      btn_q <= 1'b0;
    end else begin
      sel   <= sel_nxt;
      grant <= grant_nxt;
      PTR   <= grant_nxt;
      dat   <= dat_nxt;
      CEO   <= ceo_nxt;
      dwell <= dwell_nxt;
      btn_q <= btn_next;
    end
  end

endmodule

// File: tb/tb_disp_src_sched.sv
// Directed bench for disp_src_sched with DWELL_MS=4; expected values are hand-derived.
module tb_disp_src_sched;

  localparam int unsigned DWELL = 4;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        ce1ms = 1'b0;
  logic [63:0] src_dat = {16'hD003, 16'hC002, 16'h1234, 16'hA000};
  logic [3:0]  src_req = 4'b0000;
  logic        mode = 1'b0;
  logic        btn_next = 1'b0;
  logic [15:0] dat;
  logic [3:0]  PTR;
  logic [3:0]  grant;
  logic [1:0]  sel;
  logic        CEO;

  int n_chk = 0;
  int n_fail = 0;
  int ceo_cnt = 0;
  int c0;

  logic [3:0]  exp_g [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [15:0] exp_d [4] = '{16'hC002, 16'hD003, 16'hA000, 16'h1234};

  disp_src_sched #(.DWELL_MS(DWELL)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .ce1ms    (ce1ms),
    .src_dat  (src_dat),
    .src_req  (src_req),
    .mode     (mode),
    .btn_next (btn_next),
    .dat      (dat),
    .PTR      (PTR),
    .grant    (grant),
    .sel      (sel),
    .CEO      (CEO)
  );

  always #5 clk = ~clk;

  // Count every cycle in which CEO is high.
  always @(posedge clk) begin
    #1;
    if (CEO) ceo_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    ce1ms = 1'b1;
    @(negedge clk);
    ce1ms = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    cyc(2);
    check("rst_grant", grant, 4'b0000);
    check("rst_ptr", PTR, 4'b0000);
    check("rst_dat", dat, 16'h0000);
    check("rst_sel", sel, 2'd0);
    check("rst_ceo", CEO, 1'b0);

    // Auto rotation over all four sources
    clr_n   = 1'b1;
    src_req = 4'b1111;
    cyc(1);
    check("first_grant", grant, 4'b0010);
    check("first_ptr", PTR, 4'b0010);
    check("first_dat", dat, 16'h1234);
    check("first_ceo", CEO, 1'b1);
    c0 = ceo_cnt;
    for (int k = 0; k < 4; k++) begin
      ticks(DWELL - 1);
      check("rot_hold", grant, (k == 0) ? 4'b0010 : exp_g[k-1]);
      tick();
      check("rot_grant", grant, exp_g[k]);
      check("rot_ptr", PTR, exp_g[k]);
      check("rot_dat", dat, exp_d[k]);
      check("rot_ceo", CEO, 1'b1);
    end
    check("rot_ceo_cnt", ceo_cnt - c0, 4);

    // Single requester held, then idle
    src_req = 4'b0100;
    cyc(1);
    check("single_grant", grant, 4'b0100);
    c0 = ceo_cnt;
    ticks(20);
    check("single_hold", grant, 4'b0100);
    check("single_no_ceo", ceo_cnt - c0, 0);
    src_req = 4'b0000;
    cyc(1);
    check("idle_grant", grant, 4'b0000);
    check("idle_ptr", PTR, 4'b0000);
    check("idle_dat", dat, 16'h0000);
    check("idle_sel", sel, 2'd2);
    check("idle_ceo", CEO, 1'b1);

    // Manual mode: held button gives exactly one switch
    mode    = 1'b1;
    src_req = 4'b0010;
    cyc(1);
    check("man_start", grant, 4'b0010);
    src_req = 4'b1010;
    ticks(5);
    check("man_no_tick", grant, 4'b0010);
    c0 = ceo_cnt;
    btn_next = 1'b1;
    cyc(100);
    btn_next = 1'b0;
    check("man_btn", grant, 4'b1000);
    check("man_btn_ceo", ceo_cnt - c0, 1);
    ticks(5);
    check("man_frozen", grant, 4'b1000);
    mode = 1'b0;
    ticks(DWELL - 1);
    check("resume_hold", grant, 4'b1000);
    tick();
    check("resume_switch", grant, 4'b0010);

    // Granted source drops mid-dwell; counter restarts
    src_req = 4'b1100;
    cyc(1);
    check("drop_pre", grant, 4'b0100);
    ticks(2);
    src_req = 4'b1010;
    cyc(1);
    check("drop_grant", grant, 4'b1000);
    check("drop_ceo", CEO, 1'b1);
    ticks(DWELL - 1);
    check("drop_restart", grant, 4'b1000);
    tick();
    check("drop_expire", grant, 4'b0010);

    // Asynchronous reset mid-dwell
    ticks(2);
    #2 clr_n = 1'b0;
    #1;
    check("arst_grant", grant, 4'b0000);
    check("arst_ptr", PTR, 4'b0000);
    check("arst_dat", dat, 16'h0000);
    check("arst_sel", sel, 2'd0);
    check("arst_ceo", CEO, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    cyc(1);
    check("post_rst_grant", grant, 4'b0010);
    check("post_rst_sel", sel, 2'd1);
    check("post_rst_ceo", CEO, 1'b1);

    // Source 0 request while source 2 is shown
    src_req = 4'b0100;
    cyc(1);
    check("s2_grant", grant, 4'b0100);
    src_req = 4'b0101;
    cyc(1);
`ifdef SCHED_PRIO_EN
    check("prio_grant", grant, 4'b0001);
    check("prio_ceo", CEO, 1'b1);
    ticks(2 * DWELL);
    check("prio_hold", grant, 4'b0001);
`else
    check("rr_wait", grant, 4'b0100);
    check("rr_no_ceo", CEO, 1'b0);
    ticks(DWELL - 1);
    check("rr_hold", grant, 4'b0100);
    tick();
    check("rr_turn", grant, 4'b0001);
`endif

    // Data follows the granted source with one cycle of latency
    src_dat[15:0] = 16'hBEEF;
    cyc(1);
    check("dat_follow", dat, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
